// File: rtl/count_trend_pkg.sv
// Shared types and constants for the count trend observer.
// Event and direction encodings match the values seen on the output bus.
package count_trend_pkg;

    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        EvtHold = 2'd0,
        EvtUp   = 2'd1,
        EvtDn   = 2'd2,
        EvtLoad = 2'd3
    } evt_t;

    typedef enum logic [1:0] {
        DirNoref = 2'd0,
        DirUp    = 2'd1,
        DirDn    = 2'd2,
        DirIdle  = 2'd3
    } dir_t;

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/count_trend_decoder_if.sv
// Sample/event bus between a count stream source (master) and the trend decoder (slave).
// COUNT_TREND_STATS_EN adds the statistics clear input and event counters.
interface count_trend_decoder_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned RUN_W = 8
);
    import count_trend_pkg::*;

    logic             smp_valid;
    logic [W-1:0]     cnt_in;
    logic             evt_valid;
    evt_t             evt;
    logic             wrap;
    dir_t             dir;
    logic [RUN_W-1:0] run_len;
    logic             dir_chg;
`ifdef COUNT_TREND_STATS_EN
    logic              stats_clr;
    logic [STAT_W-1:0] n_up;
    logic [STAT_W-1:0] n_dn;
    logic [STAT_W-1:0] n_load;
    logic [STAT_W-1:0] n_wrap;

    modport master (
        output smp_valid, cnt_in, stats_clr,
        input  evt_valid, evt, wrap, dir, run_len, dir_chg, n_up, n_dn, n_load, n_wrap
    );
    modport slave (
        input  smp_valid, cnt_in, stats_clr,
        output evt_valid, evt, wrap, dir, run_len, dir_chg, n_up, n_dn, n_load, n_wrap
    );
`else
    modport master (
        output smp_valid, cnt_in,
        input  evt_valid, evt, wrap, dir, run_len, dir_chg
    );
    modport slave (
        input  smp_valid, cnt_in,
        output evt_valid, evt, wrap, dir, run_len, dir_chg
    );
`endif

endinterface

// File: rtl/count_delta_classify.sv
// Combinational classifier of one counter transition (prev -> cur), modulo 2^W.
module count_delta_classify
    import count_trend_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] prev_i,
    input  logic [W-1:0] cur_i,
    output evt_t         evt_o,
    output logic         wrap_o
);

    logic [W-1:0] delta;

    always_comb begin
        delta = cur_i - prev_i;
        evt_o = EvtLoad;
        if (delta == '0) begin
            evt_o = EvtHold;
        end else if (delta == W'(1)) begin
            evt_o = EvtUp;
        end else if (delta == '1) begin
            evt_o = EvtDn;
        end
        wrap_o = ((evt_o == EvtUp) && (prev_i == '1)) || ((evt_o == EvtDn) && (prev_i == '0));
    end

endmodule

// File: rtl/count_trend_decoder.sv
// Observes a W-bit up/down counter stream and reports step events, direction and run length.
// COUNT_TREND_STATS_EN adds saturating per-event statistics counters.
module count_trend_decoder
    import count_trend_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned RUN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    count_trend_decoder_if.slave bus
);

    logic [W-1:0]     prev_q, prev_d;
    dir_t             dir_q, dir_d;
    logic             evt_valid_q, evt_valid_d;
    evt_t             evt_q, evt_d;
    logic             wrap_q, wrap_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             dir_chg_q, dir_chg_d;

    evt_t cls_evt;
    logic cls_wrap;

    count_delta_classify #(.W(W)) u_classify (
        .prev_i (prev_q),
        .cur_i  (bus.cnt_in),
        .evt_o  (cls_evt),
        .wrap_o (cls_wrap)
    );

    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
        return (v == '1) ? v : v + RUN_W'(1);
    endfunction

    always_comb begin
        prev_d      = prev_q;
        dir_d       = dir_q;
        run_len_d   = run_len_q;
        evt_d       = evt_q;
        wrap_d      = wrap_q;
        evt_valid_d = 1'b0;
        dir_chg_d   = 1'b0;
        if (bus.smp_valid) begin
            prev_d = bus.cnt_in;
            if (dir_q == DirNoref) begin
                // First sample only establishes the reference value.
                dir_d     = DirIdle;
                run_len_d = '0;
            end else begin
                evt_valid_d = 1'b1;
                evt_d       = cls_evt;
                wrap_d      = cls_wrap;
                unique case (cls_evt)
                    EvtUp: begin
                        dir_d     = DirUp;
                        run_len_d = (dir_q == DirUp) ? run_inc(run_len_q) : RUN_W'(1);
                        dir_chg_d = (dir_q == DirDn);
                    end
                    EvtDn: begin
                        dir_d     = DirDn;
                        run_len_d = (dir_q == DirDn) ? run_inc(run_len_q) : RUN_W'(1);
                        dir_chg_d = (dir_q == DirUp);
                    end
                    EvtLoad: begin
                        dir_d     = DirIdle;
                        run_len_d = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            dir_q       <= DirNoref;
            evt_valid_q <= 1'b0;
            evt_q       <= EvtHold;
            wrap_q      <= 1'b0;
            run_len_q   <= '0;
            dir_chg_q   <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            dir_q       <= dir_d;
            evt_valid_q <= evt_valid_d;
            evt_q       <= evt_d;
            wrap_q      <= wrap_d;
            run_len_q   <= run_len_d;
            dir_chg_q   <= dir_chg_d;
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt       = evt_q;
    assign bus.wrap      = wrap_q;
    assign bus.dir       = dir_q;
    assign bus.run_len   = run_len_q;
    assign bus.dir_chg   = dir_chg_q;

`ifdef COUNT_TREND_STATS_EN
    logic [STAT_W-1:0] n_up_q, n_dn_q, n_load_q, n_wrap_q;

    // Counted from next-state so the counters move together with evt_valid.
    always_ff @(posedge clk) begin
        if (rst || bus.stats_clr) begin
            n_up_q   <= '0;
            n_dn_q   <= '0;
            n_load_q <= '0;
            n_wrap_q <= '0;
        end else if (evt_valid_d) begin
            if (evt_d == EvtUp)   n_up_q   <= stat_inc(n_up_q);
            if (evt_d == EvtDn)   n_dn_q   <= stat_inc(n_dn_q);
            if (evt_d == EvtLoad) n_load_q <= stat_inc(n_load_q);
            if (wrap_d)           n_wrap_q <= stat_inc(n_wrap_q);
        end
    end

    assign bus.n_up   = n_up_q;
    assign bus.n_dn   = n_dn_q;
    assign bus.n_load = n_load_q;
    assign bus.n_wrap = n_wrap_q;
`endif

endmodule

// File: tb/tb_count_trend_decoder.sv
// Directed table-driven bench for count_trend_decoder and its delta classifier.
module tb_count_trend_decoder;
    import count_trend_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned RUN_W = 8;
    localparam int          NVEC  = 28;

    typedef struct {
        logic             rst;
        logic             smp;
        logic [W-1:0]     cnt;
        logic             ev;
        logic [1:0]       evt;
        logic             wrap;
        logic [1:0]       dir;
        logic [RUN_W-1:0] run;
        logic             chg;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    count_trend_decoder_if #(.W(W), .RUN_W(RUN_W)) bus ();

    count_trend_decoder #(.W(W), .RUN_W(RUN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] cp, cc;
    evt_t         ce;
    logic         cw;

    count_delta_classify #(.W(W)) u_cls (
        .prev_i (cp),
        .cur_i  (cc),
        .evt_o  (ce),
        .wrap_o (cw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic [W-1:0] c);
        @(negedge clk);
        rst           = r;
        bus.smp_valid = s;
        bus.cnt_in    = c;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic s, input int c, input logic ev,
                                input int evt, input logic wrap, input int dir,
                                input int run, input logic chg);
        vec_t v;
        v.rst = r; v.smp = s; v.cnt = W'(c); v.ev = ev; v.evt = 2'(evt); v.wrap = wrap;
        v.dir = 2'(dir); v.run = RUN_W'(run); v.chg = chg;
        return v;
    endfunction

    vec_t vecs[NVEC];

    initial begin
        // dir: 0 NOREF, 1 UP, 2 DN, 3 IDLE; evt: 0 HOLD, 1 UP, 2 DN, 3 LOAD
        vecs[0]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1,  3, 0, 0, 0, 3, 0, 0);
        vecs[2]  = mk(0, 1,  4, 1, 1, 0, 1, 1, 0);
        vecs[3]  = mk(0, 1,  5, 1, 1, 0, 1, 2, 0);
        vecs[4]  = mk(0, 1,  6, 1, 1, 0, 1, 3, 0);
        vecs[5]  = mk(0, 1, 14, 1, 3, 0, 3, 0, 0);
        vecs[6]  = mk(0, 1, 15, 1, 1, 0, 1, 1, 0);
        vecs[7]  = mk(0, 1,  0, 1, 1, 1, 1, 2, 0);
        vecs[8]  = mk(0, 1,  1, 1, 1, 0, 1, 3, 0);
        vecs[9]  = mk(0, 1,  0, 1, 2, 0, 2, 1, 1);
        vecs[10] = mk(0, 1, 15, 1, 2, 1, 2, 2, 0);
        vecs[11] = mk(0, 1, 14, 1, 2, 0, 2, 3, 0);
        vecs[12] = mk(0, 1,  5, 1, 3, 0, 3, 0, 0);
        vecs[13] = mk(0, 1,  5, 1, 0, 0, 3, 0, 0);
        vecs[14] = mk(0, 1,  6, 1, 1, 0, 1, 1, 0);
        vecs[15] = mk(0, 1,  6, 1, 0, 0, 1, 1, 0);
        vecs[16] = mk(0, 1, 10, 1, 3, 0, 3, 0, 0);
        vecs[17] = mk(0, 1, 11, 1, 1, 0, 1, 1, 0);
        vecs[18] = mk(0, 1,  7, 1, 3, 0, 3, 0, 0);
        vecs[19] = mk(0, 0,  9, 0, 0, 0, 3, 0, 0);
        vecs[20] = mk(0, 0,  3, 0, 0, 0, 3, 0, 0);
        vecs[21] = mk(0, 1,  8, 1, 1, 0, 1, 1, 0);
        vecs[22] = mk(0, 1,  9, 1, 1, 0, 1, 2, 0);
        vecs[23] = mk(1, 1, 10, 0, 0, 0, 0, 0, 0);
        vecs[24] = mk(0, 1, 11, 0, 0, 0, 3, 0, 0);
        vecs[25] = mk(0, 1, 12, 1, 1, 0, 1, 1, 0);
        vecs[26] = mk(0, 1, 11, 1, 2, 0, 2, 1, 1);
        vecs[27] = mk(0, 1, 12, 1, 1, 0, 1, 1, 1);

        bus.smp_valid = 1'b0;
        bus.cnt_in    = '0;
`ifdef COUNT_TREND_STATS_EN
        bus.stats_clr = 1'b0;
`endif

        // Standalone classifier corner cases.
        cp = 4'd15; cc = 4'd0;  #1; chk("cls_evt", 0, 32'(ce), 1); chk("cls_wrap", 0, 32'(cw), 1);
        cp = 4'd0;  cc = 4'd15; #1; chk("cls_evt", 1, 32'(ce), 2); chk("cls_wrap", 1, 32'(cw), 1);
        cp = 4'd3;  cc = 4'd3;  #1; chk("cls_evt", 2, 32'(ce), 0); chk("cls_wrap", 2, 32'(cw), 0);
        cp = 4'd3;  cc = 4'd5;  #1; chk("cls_evt", 3, 32'(ce), 3); chk("cls_wrap", 3, 32'(cw), 0);
        cp = 4'd7;  cc = 4'd6;  #1; chk("cls_evt", 4, 32'(ce), 2); chk("cls_wrap", 4, 32'(cw), 0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rst, vecs[i].smp, vecs[i].cnt);
            chk("evt_valid", i, 32'(bus.evt_valid), 32'(vecs[i].ev));
            chk("dir", i, 32'(bus.dir), 32'(vecs[i].dir));
            chk("run_len", i, 32'(bus.run_len), 32'(vecs[i].run));
            chk("dir_chg", i, 32'(bus.dir_chg), 32'(vecs[i].chg));
            if (vecs[i].ev || vecs[i].rst) begin
                chk("evt", i, 32'(bus.evt), 32'(vecs[i].evt));
                chk("wrap", i, 32'(bus.wrap), 32'(vecs[i].wrap));
            end
        end

        // Long up run: run_len must saturate at all-ones.
        apply(1'b1, 1'b0, '0);
        apply(1'b0, 1'b1, '0);
        for (int k = 1; k <= 260; k++) apply(1'b0, 1'b1, W'(k));
        chk("run_sat", 0, 32'(bus.run_len), 255);
        chk("run_sat_dir", 0, 32'(bus.dir), 1);
        apply(1'b0, 1'b0, '0);
        chk("run_sat_hold", 0, 32'(bus.run_len), 255);

`ifdef COUNT_TREND_STATS_EN
        apply(1'b1, 1'b0, '0);
        chk("n_up_rst", 0, 32'(bus.n_up), 0);
        apply(1'b0, 1'b1, '0);
        for (int k = 1; k <= 20; k++) apply(1'b0, 1'b1, W'(k));
        apply(1'b0, 1'b1, 4'd9);
        apply(1'b0, 1'b1, 4'd2);
        apply(1'b0, 1'b1, 4'd12);
        chk("n_up", 0, 32'(bus.n_up), 20);
        chk("n_dn", 0, 32'(bus.n_dn), 0);
        chk("n_load", 0, 32'(bus.n_load), 3);
        chk("n_wrap", 0, 32'(bus.n_wrap), 1);
        @(negedge clk);
        bus.stats_clr = 1'b1;
        apply(1'b0, 1'b1, 4'd13);
        bus.stats_clr = 1'b0;
        chk("n_up_clr", 0, 32'(bus.n_up), 0);
        chk("n_load_clr", 0, 32'(bus.n_load), 0);
        chk("n_wrap_clr", 0, 32'(bus.n_wrap), 0);
        apply(1'b0, 1'b1, 4'd14);
        chk("n_up_after", 0, 32'(bus.n_up), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
